voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Time-multiplexes one shared waveform datapath (phase in, signed sample out) across NUM_VOICES voices in each audio sample period.
- Started by a one-cycle sample tick derived from the I2S LRCK divider.
- Owns the per-voice phase accumulators, issues one datapath request per enabled voice, and sums the returned samples.
- Presents the mixed word to the I2S serializer with a valid/ready handshake.

Parameters:
- NUM_VOICES, 4, number of voices sharing the datapath (power of two, ≥2).
- PHASE_W, 8, phase accumulator and increment width.
- SAMPLE_W, 8, signed datapath sample width.
- OUT_W, 16, signed mixed output width. Must satisfy OUT_W ≥ ACC_W, where ACC_W = SAMPLE_W + log2(NUM_VOICES).
- DP_LAT, 2, fixed datapath latency in cycles (≥1).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; asynchronous, active-low.
- sample_tick  in  1  one-cycle pulse marking the start of a sample period.
- voice_en  in  NUM_VOICES  per-voice enable.
- voice_inc  in  NUM_VOICES*PHASE_W  per-voice phase increment; voice i occupies bits [i*PHASE_W +: PHASE_W].
- dp_req  out  1  datapath request valid.
- dp_phase  out  PHASE_W  phase presented to the datapath.
- dp_sample  in  SAMPLE_W  signed datapath result, valid exactly DP_LAT cycles after dp_req.
- mix_data  out  OUT_W  signed mixed sample.
- mix_valid  out  1  mix_data valid; held until accepted.
- mix_ready  in  1  serializer accepts mix_data.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (rst=0, async): state=IDLE; all phases=0, accumulator=0, tag pipe cleared; dp_req=0, dp_phase=0, mix_data=0, mix_valid=0, busy=0, overrun=0. A reset mid-frame discards the frame in progress.
- FSM states: IDLE, ISSUE, DRAIN, PRESENT.
- IDLE:
  - On sample_tick: clear acc, set idx=0, go to ISSUE.
- ISSUE (exactly NUM_VOICES cycles, idx=0..NUM_VOICES-1):
  - dp_phase = phase[idx].
  - dp_req = voice_en[idx].
  - If the voice is enabled, phase[idx] <= phase[idx] + voice_inc[idx], modulo 2^PHASE_W (wrap, no saturation); voice_inc is sampled in this cycle.
  - If the voice is disabled, dp_req=0 and its phase holds.
  - After the last idx, go to DRAIN.
- Tag pipe (DP_LAT-deep shift register of dp_req):
  - When the tag output is 1, acc <= acc + sign-extended dp_sample.
  - Results with tag 0 are ignored.
- DRAIN:
  - Stay until the tag pipe is empty (DP_LAT cycles), then go to PRESENT.
  - On entry to PRESENT, mix_data <= acc sign-extended and left-shifted by (OUT_W-ACC_W). This is exact; no clipping is possible.
- PRESENT:
  - mix_valid=1; mix_data stays stable while mix_ready=0.
  - On mix_valid & mix_ready: clear mix_valid, go to IDLE.
- Latency: a tick at cycle T gives ISSUE in T+1..T+NUM_VOICES and mix_valid at T+NUM_VOICES+DP_LAT+1 (T+7 with defaults).
- Tick while busy:
  - In ISSUE, DRAIN, or PRESENT without a handshake: the tick is ignored, overrun pulses for 1 cycle, and no phase advances.
  - Tick in the same cycle as a PRESENT handshake: the tick is accepted with no overrun; go directly to ISSUE with acc cleared.
- All voices disabled: the frame still runs its full duration and outputs mix_data=0.
- dp_phase outside ISSUE holds its last value; dp_req=0.

Decomposition:
- synth_pkg contains:
  - widths and defaults (PHASE_W, SAMPLE_W, OUT_W, NUM_VOICES, DP_LAT).
  - derived ACC_W.
  - FSM state encoding (IDLE/ISSUE/DRAIN/PRESENT).
- One sub-module, voice_phase_bank:
  - NUM_VOICES phase registers with indexed read and conditional wrap-add on write.
  - Async active-low reset to 0.

Test Plan:
- Reset mid-frame: assert rst low during ISSUE → all outputs 0 immediately; the next tick starts with dp_phase=0x00 for voice 0.
- Single voice, identity datapath model:
  - Setup: voice_en=0001, inc0=0x10, dp model returns phase as signed, mix_ready=1.
  - Tick1 → dp_phase 0x00, mix_data 0x0000 at T+7.
  - Tick2 → dp_phase 0x10, mix_data 0x0400.
- Full-scale mix with all four voices enabled:
  - dp returns 0x80 (-128) → mix_data 0x8000.
  - dp returns 0x7F → mix_data 0x7F00.
- Backpressure: hold mix_ready=0 for 20 cycles with a tick arriving mid-hold → mix_data stable, one overrun pulse, voice phases unchanged; release ready → handshake completes, busy drops.
- Simultaneous tick and handshake in the same cycle → no overrun; next mix_valid exactly 7 cycles later.
- Phase wrap: voice_en=0001, inc0=0xC0, four ticks → dp_phase 0x00, 0xC0, 0x80, 0x40.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler slice: default widths, the
// derived accumulator width and the frame FSM state encoding.
package voice_scheduler_pkg;

   localparam int DEF_NUM_VOICES = 4;
   localparam int DEF_PHASE_W    = 8;
   localparam int DEF_SAMPLE_W   = 8;
   localparam int DEF_OUT_W      = 16;
   localparam int DEF_DP_LAT     = 2;

   // Width needed to sum num_voices signed samples without overflow.
   function automatic int acc_width(input int sample_w, input int num_voices);
      return sample_w + $clog2(num_voices);
   endfunction

   localparam int DEF_ACC_W = acc_width(DEF_SAMPLE_W, DEF_NUM_VOICES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_PRESENT = 2'd3
   } state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Bus bundle between the scheduler, the shared waveform datapath and the
// I2S serializer.
//   dp_req/dp_phase : request to the datapath (scheduler drives)
//   dp_sample       : signed datapath result, DP_LAT cycles after dp_req
//   mix_data/valid  : mixed word to the serializer (scheduler drives)
//   mix_ready       : serializer accepts mix_data
interface voice_scheduler_if #(
   parameter int PHASE_W  = voice_scheduler_pkg::DEF_PHASE_W,
   parameter int SAMPLE_W = voice_scheduler_pkg::DEF_SAMPLE_W,
   parameter int OUT_W    = voice_scheduler_pkg::DEF_OUT_W
);
   logic                dp_req;
   logic [PHASE_W-1:0]  dp_phase;
   logic [SAMPLE_W-1:0] dp_sample;
   logic [OUT_W-1:0]    mix_data;
   logic                mix_valid;
   logic                mix_ready;

   modport master (
      output dp_req, dp_phase, mix_data, mix_valid,
      input  dp_sample, mix_ready
   );

   modport slave (
      input  dp_req, dp_phase, mix_data, mix_valid,
      output dp_sample, mix_ready
   );
endinterface

// File: rtl/voice_scheduler_phase_bank.sv
// Per-voice phase accumulators. One voice is addressed at a time: its phase
// is read combinationally and, when wr_en is set, advanced by wr_inc with
// natural wrap-around.
//   clk, rst  : clock, async active-low reset (phases go to 0)
//   rd_idx    : addressed voice
//   rd_phase  : current phase of the addressed voice
//   wr_en     : advance the addressed voice this cycle
//   wr_inc    : increment applied to the addressed voice
module voice_phase_bank #(
   parameter int NUM_VOICES = voice_scheduler_pkg::DEF_NUM_VOICES,
   parameter int PHASE_W    = voice_scheduler_pkg::DEF_PHASE_W
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(NUM_VOICES)-1:0] rd_idx,
   output logic [PHASE_W-1:0]            rd_phase,
   input  logic                          wr_en,
   input  logic [PHASE_W-1:0]            wr_inc
);
   logic [PHASE_W-1:0] phase_r [NUM_VOICES];

   assign rd_phase = phase_r[rd_idx];

   // Wrap-add into the addressed voice; all other voices hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            phase_r[i] <= {PHASE_W{1'b0}};
         end
      end else if (wr_en) begin
         phase_r[rd_idx] <= rd_phase + wr_inc;
      end
   end
endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one waveform datapath across NUM_VOICES voices per sample
// period, sums the returned samples and offers the mix to the serializer.
//   clk, rst    : clock, async active-low reset
//   sample_tick : one-cycle pulse starting a sample period
//   voice_en    : per-voice enable
//   voice_inc   : per-voice phase increment, voice i at [i*PHASE_W +: PHASE_W]
//   busy        : frame in progress (any state but IDLE)
//   overrun     : one-cycle pulse, registered, after a dropped tick
//   bus         : datapath request/result and mix valid/ready handshake
module voice_scheduler
   import voice_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = DEF_NUM_VOICES,
   parameter int PHASE_W    = DEF_PHASE_W,
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int DP_LAT     = DEF_DP_LAT
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_tick,
   input  logic [NUM_VOICES-1:0]         voice_en,
   input  logic [NUM_VOICES*PHASE_W-1:0] voice_inc,
   output logic                          busy,
   output logic                          overrun,
   voice_scheduler_if.master             bus
);
   localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
   localparam int SHIFT = OUT_W - ACC_W;
   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(NUM_VOICES + DP_LAT);

   state_t                     state_r, state_nxt_s;
   logic [CNT_W-1:0]           cnt_r;
   logic [IDX_W-1:0]           idx_s;
   logic                       last_issue_s, last_drain_s;
   logic                       issue_s, dp_req_s, start_s, handshake_s, overrun_s;
   logic [PHASE_W-1:0]         inc_arr_s [NUM_VOICES];
   logic [PHASE_W-1:0]         rd_phase_s, last_phase_r;
   logic [DP_LAT-1:0]          tag_r;
   logic signed [SAMPLE_W-1:0] samp_s;
   logic signed [ACC_W-1:0]    samp_ext_s, acc_r, acc_nxt_s;
   logic signed [OUT_W-1:0]    mix_ext_s, mix_nxt_s;
   logic [OUT_W-1:0]           mix_data_r;
   logic                       mix_valid_r, busy_r, overrun_r;

   // The slot counter doubles as voice index in ISSUE and drain timer in DRAIN.
   assign idx_s        = cnt_r[IDX_W-1:0];
   assign last_issue_s = (cnt_r == CNT_W'(NUM_VOICES - 1));
   assign last_drain_s = (cnt_r == CNT_W'(DP_LAT - 1));

   voice_phase_bank #(
      .NUM_VOICES (NUM_VOICES),
      .PHASE_W    (PHASE_W)
   ) u_phase_bank (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx_s),
      .rd_phase (rd_phase_s),
      .wr_en    (dp_req_s),
      .wr_inc   (inc_arr_s[idx_s])
   );

   // Unpack the flat increment bus into per-voice words.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         inc_arr_s[i] = voice_inc[i*PHASE_W +: PHASE_W];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a tick coinciding with the handshake chains frames.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (sample_tick) state_nxt_s = ST_ISSUE;
            else             state_nxt_s = ST_IDLE;
         end
         ST_ISSUE: begin
            if (last_issue_s) state_nxt_s = ST_DRAIN;
            else              state_nxt_s = ST_ISSUE;
         end
         ST_DRAIN: begin
            if (last_drain_s) state_nxt_s = ST_PRESENT;
            else              state_nxt_s = ST_DRAIN;
         end
         ST_PRESENT: begin
            if (bus.mix_ready) begin
               if (sample_tick) state_nxt_s = ST_ISSUE;
               else             state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode: request strobe, frame start and dropped-tick detect.
   always_comb begin
      issue_s     = 1'b0;
      dp_req_s    = 1'b0;
      start_s     = 1'b0;
      handshake_s = 1'b0;
      overrun_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = sample_tick;
         end
         ST_ISSUE: begin
            issue_s   = 1'b1;
            dp_req_s  = voice_en[idx_s];
            overrun_s = sample_tick;
         end
         ST_DRAIN: begin
            overrun_s = sample_tick;
         end
         ST_PRESENT: begin
            handshake_s = bus.mix_ready;
            start_s     = sample_tick & bus.mix_ready;
            overrun_s   = sample_tick & ~bus.mix_ready;
         end
         default: begin
            issue_s = 1'b0;
         end
      endcase
   end

   // Slot counter: restarts on frame start and between ISSUE and DRAIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (start_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_ISSUE) begin
         cnt_r <= last_issue_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1'b1);
      end else if (state_r == ST_DRAIN) begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Tag pipe: dp_req delayed to line up with the returning dp_sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_r <= {DP_LAT{1'b0}};
      end else begin
         tag_r <= DP_LAT'({tag_r, dp_req_s});
      end
   end

   // Accumulate tagged samples; the final-slot sample is folded into the
   // PRESENT word through acc_nxt_s so no extra cycle is needed.
   always_comb begin
      samp_s     = bus.dp_sample;
      samp_ext_s = ACC_W'(samp_s);
      if (tag_r[DP_LAT-1]) acc_nxt_s = acc_r + samp_ext_s;
      else                 acc_nxt_s = acc_r;
      mix_ext_s  = OUT_W'(acc_nxt_s);
      mix_nxt_s  = mix_ext_s <<< SHIFT;
   end

   // Accumulator, mix word, phase hold and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r        <= {ACC_W{1'b0}};
         mix_data_r   <= {OUT_W{1'b0}};
         mix_valid_r  <= 1'b0;
         last_phase_r <= {PHASE_W{1'b0}};
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         acc_r        <= start_s ? {ACC_W{1'b0}} : acc_nxt_s;
         last_phase_r <= issue_s ? rd_phase_s : last_phase_r;
         busy_r       <= (state_nxt_s != ST_IDLE);
         overrun_r    <= overrun_s;
         if ((state_r == ST_DRAIN) && last_drain_s) begin
            mix_data_r  <= mix_nxt_s;
            mix_valid_r <= 1'b1;
         end else if (handshake_s) begin
            mix_valid_r <= 1'b0;
         end else begin
            mix_valid_r <= mix_valid_r;
         end
      end
   end

   assign bus.dp_req    = dp_req_s;
   assign bus.dp_phase  = issue_s ? rd_phase_s : last_phase_r;
   assign bus.mix_data  = mix_data_r;
   assign bus.mix_valid = mix_valid_r;
   assign busy          = busy_r;
   assign overrun       = overrun_r;
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed frames plus randomized
// frames, checked against a phase/sum reference model.
module tb_voice_scheduler;
   localparam int NV     = 4;
   localparam int PW     = 8;
   localparam int DP_LAT = 2;

   logic          clk;
   logic          rst;
   logic          sample_tick;
   logic [NV-1:0] voice_en;
   logic [NV*PW-1:0] voice_inc;
   logic          busy;
   logic          overrun;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state.
   logic [7:0] m_phase [NV];
   int         mode;
   logic [7:0] dp_const;
   logic [7:0] dp_pipe [DP_LAT];

   voice_scheduler_if bus_if ();

   voice_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .voice_en    (voice_en),
      .voice_inc   (voice_inc),
      .busy        (busy),
      .overrun     (overrun),
      .bus         (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath function: 0 identity, 1 constant, 2 scrambled phase.
   function automatic int dp_val(input logic [7:0] ph);
      logic [7:0] v;
      case (mode)
         0:       v = ph;
         1:       v = dp_const;
         default: v = ph ^ 8'h5A;
      endcase
      return int'($signed(v));
   endfunction

   // Datapath responder with fixed latency; junk when no request.
   always @(posedge clk) begin
      dp_pipe[0] <= bus_if.dp_req ? 8'(dp_val(bus_if.dp_phase)) : 8'($urandom);
      for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign bus_if.dp_sample = dp_pipe[DP_LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dp_req"}, bus_if.dp_req, 1'b0);
      check({tag, "_dp_phase"}, bus_if.dp_phase, 8'h00);
      check({tag, "_mix_data"}, bus_if.mix_data, 16'h0000);
      check({tag, "_mix_valid"}, bus_if.mix_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_overrun"}, overrun, 1'b0);
   endtask

   // Tick at the current negedge, check the ISSUE slots and drain, and stop
   // at the first negedge where mix_valid should be high.
   task automatic issue_frame(output logic [15:0] exp_mix);
      int sum;
      int waitc;
      logic [7:0] last_ph;
      sum = 0;
      last_ph = 8'h00;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      for (int i = 0; i < NV; i++) begin
         check("issue_req", bus_if.dp_req, voice_en[i]);
         check("issue_phase", bus_if.dp_phase, m_phase[i]);
         check("issue_busy", busy, 1'b1);
         check("issue_overrun", overrun, 1'b0);
         last_ph = m_phase[i];
         if (voice_en[i]) begin
            sum += dp_val(m_phase[i]);
            m_phase[i] = m_phase[i] + voice_inc[i*PW +: PW];
         end
         @(negedge clk);
      end
      exp_mix = 16'(sum * 64);
      waitc = 0;
      while (bus_if.mix_valid !== 1'b1 && waitc < 12) begin
         check("drain_req", bus_if.dp_req, 1'b0);
         check("drain_phase_hold", bus_if.dp_phase, last_ph);
         @(negedge clk);
         waitc++;
      end
      check("mix_latency", waitc, DP_LAT);
      check("mix_data", bus_if.mix_data, exp_mix);
   endtask

   task automatic after_handshake();
      @(negedge clk);
      check("hs_valid_clear", bus_if.mix_valid, 1'b0);
      check("hs_busy_clear", busy, 1'b0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NV; i++) m_phase[i] = 8'h00;
   endtask

   initial begin
      logic [15:0] em;
      logic [15:0] em2;
      int ov;
      rst = 1'b0;
      sample_tick = 1'b0;
      voice_en = '0;
      voice_inc = '0;
      bus_if.mix_ready = 1'b1;
      mode = 0;
      dp_const = 8'h00;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;
      @(negedge clk);

      // Single voice, identity datapath.
      voice_en = 4'b0001;
      voice_inc = 32'h0000_0010;
      issue_frame(em);
      check("single_tick1", bus_if.mix_data, 16'h0000);
      after_handshake();
      issue_frame(em);
      check("single_tick2", bus_if.mix_data, 16'h0400);
      after_handshake();

      // Full-scale mixes with all voices enabled.
      voice_en = 4'b1111;
      voice_inc = $urandom;
      mode = 1;
      dp_const = 8'h80;
      issue_frame(em);
      check("full_neg", bus_if.mix_data, 16'h8000);
      after_handshake();
      dp_const = 8'h7F;
      issue_frame(em);
      check("full_pos", bus_if.mix_data, 16'h7F00);
      after_handshake();

      // Backpressure with a dropped tick mid-hold.
      mode = 2;
      voice_en = 4'b1011;
      voice_inc = $urandom;
      bus_if.mix_ready = 1'b0;
      issue_frame(em);
      ov = 0;
      for (int k = 0; k < 20; k++) begin
         sample_tick = (k == 5);
         @(negedge clk);
         sample_tick = 1'b0;
         ov += int'(overrun);
         check("bp_valid", bus_if.mix_valid, 1'b1);
         check("bp_stable", bus_if.mix_data, em);
      end
      check("bp_overrun_count", ov, 1);
      bus_if.mix_ready = 1'b1;
      after_handshake();
      // Phases must not have moved: the model was not advanced for the drop.
      issue_frame(em);
      after_handshake();

      // Tick in the same cycle as the handshake chains straight into ISSUE.
      bus_if.mix_ready = 1'b0;
      issue_frame(em);
      bus_if.mix_ready = 1'b1;
      issue_frame(em2);
      after_handshake();

      // Reset in the middle of ISSUE.
      voice_en = 4'b0001;
      voice_inc = 32'h0000_0010;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);

      // Phase wrap on voice 0: 0x00, 0xC0, 0x80, 0x40.
      mode = 0;
      voice_inc = 32'h0000_00C0;
      for (int f = 0; f < 4; f++) begin
         issue_frame(em);
         after_handshake();
      end
      check("wrap_final_phase", m_phase[0], 8'h00);

      // All voices disabled still runs a full frame and yields zero.
      voice_en = 4'b0000;
      mode = 2;
      issue_frame(em);
      check("all_off_mix", bus_if.mix_data, 16'h0000);
      after_handshake();

      // Randomized frames.
      for (int f = 0; f < 8; f++) begin
         voice_en = 4'($urandom_range(0, 15));
         voice_inc = $urandom;
         mode = (f % 3 == 0) ? 0 : 2;
         issue_frame(em);
         after_handshake();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
